// File: rtl/nes_cart_pkg.sv
// Shared definitions for the cartridge load path: loader states, iNES magic,
// payload sizing constants and the field layout of mapper_flags.
package nes_cart_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_TRAINER,
        ST_PRG,
        ST_CHR,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    // "NES\x1A", byte 0 in the least significant lane
    localparam logic [31:0] INES_MAGIC = 32'h1A53454E;

    localparam int PRG_BANK_SHIFT = 14;
    localparam int CHR_BANK_SHIFT = 13;
    localparam int TRAINER_BYTES  = 512;

    localparam int MF_PRG_LSB    = 0;
    localparam int MF_CHR_LSB    = 8;
    localparam int MF_FLAGS6_LSB = 16;
    localparam int MF_FLAGS7_LSB = 24;

endpackage

// File: rtl/nes_game_loader_if.sv
// Byte stream in from the flash loader and write port out to cartridge memory.
interface nes_game_loader_if;
    logic [7:0]  indata;
    logic        indata_valid;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;

    modport master (
        input  indata,
        input  indata_valid,
        output mem_addr,
        output mem_data,
        output mem_write
    );

    modport slave (
        output indata,
        output indata_valid,
        input  mem_addr,
        input  mem_data,
        input  mem_write
    );
endinterface

// File: rtl/ines_header_parser.sv
// Walks the 16-byte iNES header: magic check, field latches and the
// same-cycle hdr_ok / hdr_bad verdicts the payload FSM acts on.
module ines_header_parser
    import nes_cart_pkg::*;
#(
    parameter logic [7:0] MAX_PRG_BANKS = 8'd128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        hdr_ok,
    output logic        hdr_bad,
    output logic [7:0]  prg_banks,
    output logic [7:0]  chr_banks,
    output logic        has_trainer,
    output logic [31:0] mapper_flags
);

    logic [3:0]  byte_cnt_reg;
    logic [7:0]  prg_banks_reg;
    logic [7:0]  chr_banks_reg;
    logic [7:0]  flags6_reg;
    logic [7:0]  flags7_reg;
    logic [31:0] mapper_flags_reg;
    logic [3:0]  magic_ok;
    logic        magic_bad;
    logic        banks_bad;
    logic        last_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_magic
            assign magic_ok[gi] = (byte_data == INES_MAGIC[gi*8 +: 8]);
        end
    endgenerate

    // Verdicts are combinational so the FSM can move on the strobe itself,
    // giving ERROR/PRG entry one cycle after the deciding byte.
    assign magic_bad = (byte_cnt_reg < 4'd4) && !magic_ok[byte_cnt_reg[1:0]];
    assign banks_bad = (prg_banks_reg == 8'd0) || (prg_banks_reg > MAX_PRG_BANKS);
    assign last_byte = (byte_cnt_reg == 4'd15);
    assign hdr_bad   = byte_valid && (magic_bad || (last_byte && banks_bad));
    assign hdr_ok    = byte_valid && last_byte && !banks_bad;

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_reg     <= 4'd0;
            prg_banks_reg    <= 8'd0;
            chr_banks_reg    <= 8'd0;
            flags6_reg       <= 8'd0;
            flags7_reg       <= 8'd0;
            mapper_flags_reg <= 32'd0;
        end else if (byte_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 4'd1;
            case (byte_cnt_reg)
                4'd4:    prg_banks_reg <= byte_data;
                4'd5:    chr_banks_reg <= byte_data;
                4'd6:    flags6_reg    <= byte_data;
                4'd7:    flags7_reg    <= byte_data;
                default: ;
            endcase
            if (last_byte) begin
                mapper_flags_reg[MF_PRG_LSB    +: 8] <= prg_banks_reg;
                mapper_flags_reg[MF_CHR_LSB    +: 8] <= chr_banks_reg;
                mapper_flags_reg[MF_FLAGS6_LSB +: 8] <= flags6_reg;
                mapper_flags_reg[MF_FLAGS7_LSB +: 8] <= flags7_reg;
            end
        end
    end

    assign prg_banks    = prg_banks_reg;
    assign chr_banks    = chr_banks_reg;
    assign has_trainer  = flags6_reg[2];
    assign mapper_flags = mapper_flags_reg;

endmodule

// File: rtl/nes_game_loader.sv
// Consumes the flash loader byte stream, strips the iNES header and trainer,
// and writes PRG then CHR bytes to cartridge memory one cycle after each strobe.
module nes_game_loader
    import nes_cart_pkg::*;
#(
    parameter logic [21:0] PRG_BASE      = 22'h000000,
    parameter logic [21:0] CHR_BASE      = 22'h200000,
    parameter logic [7:0]  MAX_PRG_BANKS = 8'd128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reload,
    nes_game_loader_if.master  bus,
    output logic [31:0]        mapper_flags,
    output logic               busy,
    output logic               done,
    output logic               error
);

    load_state_t state_reg;
    logic [21:0] offset_reg;
    logic [21:0] mem_addr_reg;
    logic [7:0]  mem_data_reg;
    logic        mem_write_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        error_reg;

    logic        restart;
    logic        hdr_byte_valid;
    logic        hdr_ok;
    logic        hdr_bad;
    logic [7:0]  prg_banks;
    logic [7:0]  chr_banks;
    logic        has_trainer;
    logic [21:0] prg_bytes;
    logic [20:0] chr_bytes;
    logic [21:0] prg_last;
    logic [21:0] chr_last;
    logic [21:0] trainer_last;

    assign restart        = reset || reload;
    assign hdr_byte_valid = bus.indata_valid && (state_reg == ST_HEADER);

    ines_header_parser #(
        .MAX_PRG_BANKS (MAX_PRG_BANKS)
    ) u_header (
        .clock        (clock),
        .reset        (restart),
        .byte_valid   (hdr_byte_valid),
        .byte_data    (bus.indata),
        .hdr_ok       (hdr_ok),
        .hdr_bad      (hdr_bad),
        .prg_banks    (prg_banks),
        .chr_banks    (chr_banks),
        .has_trainer  (has_trainer),
        .mapper_flags (mapper_flags)
    );

    assign prg_bytes    = 22'(prg_banks) << PRG_BANK_SHIFT;
    assign chr_bytes    = 21'(chr_banks) << CHR_BANK_SHIFT;
    assign prg_last     = prg_bytes - 22'd1;
    assign chr_last     = {1'b0, chr_bytes - 21'd1};
    assign trainer_last = 22'(TRAINER_BYTES - 1);

    always_ff @(posedge clock) begin
        if (restart) begin
            state_reg     <= ST_HEADER;
            offset_reg    <= 22'd0;
            mem_addr_reg  <= 22'd0;
            mem_data_reg  <= 8'd0;
            mem_write_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            mem_write_reg <= 1'b0;
            if (bus.indata_valid) begin
                case (state_reg)
                    ST_HEADER: begin
                        if (hdr_bad) begin
                            state_reg <= ST_ERROR;
                            error_reg <= 1'b1;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            busy_reg <= 1'b1;
                            if (hdr_ok) begin
                                state_reg  <= has_trainer ? ST_TRAINER : ST_PRG;
                                offset_reg <= 22'd0;
                            end
                        end
                    end
                    ST_TRAINER: begin
                        if (offset_reg == trainer_last) begin
                            state_reg  <= ST_PRG;
                            offset_reg <= 22'd0;
                        end else begin
                            offset_reg <= offset_reg + 22'd1;
                        end
                    end
                    ST_PRG: begin
                        assert (PRG_BASE + offset_reg < CHR_BASE);
                        mem_addr_reg  <= PRG_BASE + offset_reg;
                        mem_data_reg  <= bus.indata;
                        mem_write_reg <= 1'b1;
                        if (offset_reg == prg_last) begin
                            offset_reg <= 22'd0;
                            if (chr_banks == 8'd0) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg <= ST_CHR;
                            end
                        end else begin
                            offset_reg <= offset_reg + 22'd1;
                        end
                    end
                    ST_CHR: begin
                        mem_addr_reg  <= CHR_BASE + offset_reg;
                        mem_data_reg  <= bus.indata;
                        mem_write_reg <= 1'b1;
                        if (offset_reg == chr_last) begin
                            offset_reg <= 22'd0;
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                        end else begin
                            offset_reg <= offset_reg + 22'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_data  = mem_data_reg;
    assign bus.mem_write = mem_write_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_nes_game_loader.sv
// Scoreboarded bench: stimulus queues expected writes (address, data, cycle),
// a negedge monitor pops and compares every mem_write the loader issues.
module tb_nes_game_loader;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    localparam logic [7:0] MAGIC [4] = '{8'h4E, 8'h45, 8'h53, 8'h1A};

    logic        clock;
    logic        reset;
    logic        reload;
    logic [31:0] mapper_flags;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] cyc;
    int          checks;
    int          errors;
    wr_t         exp_q [$];

    nes_game_loader_if bus ();

    nes_game_loader u_dut (
        .clock        (clock),
        .reset        (reset),
        .reload       (reload),
        .bus          (bus),
        .mapper_flags (mapper_flags),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 32'd1;

    // Monitor: every write must match the oldest queued expectation exactly.
    always @(negedge clock) begin
        if (bus.mem_write) begin
            wr_t act;
            wr_t e;
            act = '{addr: bus.mem_addr, data: bus.mem_data, cyc: cyc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h cyc=%0d, required no write",
                         act.addr, act.data, act.cyc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             act.addr, act.data, act.cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ (i >> 7));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.indata       = b;
        bus.indata_valid = 1'b1;
        tick();
        bus.indata_valid = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Header bytes 0..14; the caller sends byte 15 so it can check around it.
    task automatic send_hdr15(input logic [7:0] prg, input logic [7:0] chr, input logic [7:0] f6);
        for (int i = 0; i < 4; i++) strobe(MAGIC[i]);
        strobe(prg);
        strobe(chr);
        strobe(f6);
        for (int i = 7; i < 15; i++) strobe(8'h00);
    endtask

    // Payload of n bytes to base; optionally with 1..3 idle cycles after every 8th byte.
    // The final byte is left to the caller.
    task automatic send_payload(input int n, input logic [21:0] base, input int seed, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = pat(i + seed);
            exp_q.push_back('{addr: base + 22'(i), data: b, cyc: cyc + 32'd1});
            strobe(b);
            if (gaps && (i % 8 == 7)) repeat (1 + (i / 8) % 3) tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(bus.mem_data), 32'd0);
        check({tag, "_mapper_flags"}, mapper_flags, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        checks = 0;
        errors = 0;
        cyc = 32'd0;
        reset = 1'b1;
        reload = 1'b0;
        bus.indata = 8'h00;
        bus.indata_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("reset");

        // Bad magic on byte 3
        strobe(8'h4E);
        check("busy_first_byte", 32'(busy), 32'd1);
        strobe(8'h45);
        strobe(8'h53);
        check("magic_pre_error", 32'(error), 32'd0);
        strobe(8'h1B);
        check("magic_error", 32'(error), 32'd1);
        check("magic_done", 32'(done), 32'd1);
        check("magic_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) strobe(8'(i));
        check("magic_error_sticky", 32'(error), 32'd1);
        do_reload();
        check_idle_outputs("reload_after_error");

        // PRG bank count out of range: 129, then 0
        send_hdr15(8'd129, 8'd1, 8'h00);
        check("prg129_pre_error", 32'(error), 32'd0);
        check("prg129_pre_busy", 32'(busy), 32'd1);
        strobe(8'h00);
        check("prg129_error", 32'(error), 32'd1);
        check("prg129_done", 32'(done), 32'd1);
        check("prg129_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) strobe(8'hA5);
        do_reload();
        send_hdr15(8'd0, 8'd1, 8'h00);
        check("prg0_pre_error", 32'(error), 32'd0);
        strobe(8'h00);
        check("prg0_error", 32'(error), 32'd1);
        check("prg0_done", 32'(done), 32'd1);
        for (int i = 0; i < 16; i++) strobe(8'h5A);
        do_reload();

        // Restart mid-PRG with reload coincident with a strobe
        send_hdr15(8'd1, 8'd1, 8'h00);
        check("restart_flags_pre", mapper_flags, 32'd0);
        strobe(8'h00);
        check("restart_flags", mapper_flags, 32'h00000101);
        send_payload(50, 22'h000000, 1000, 1'b0);
        bus.indata       = 8'hEE;
        bus.indata_valid = 1'b1;
        reload           = 1'b1;
        tick();
        bus.indata_valid = 1'b0;
        reload           = 1'b0;
        check_idle_outputs("restart");
        check("restart_pending", 32'(exp_q.size()), 32'd0);

        // Full image: 1 PRG + 1 CHR, with throughput gaps
        send_hdr15(8'd1, 8'd1, 8'h00);
        strobe(8'h00);
        check("full_flags", mapper_flags, 32'h00000101);
        send_payload(16384, 22'h000000, 0, 1'b1);
        check("full_mid_done", 32'(done), 32'd0);
        send_payload(8191, 22'h200000, 16384, 1'b1);
        check("full_pre_done", 32'(done), 32'd0);
        check("full_pre_busy", 32'(busy), 32'd1);
        b = pat(16384 + 8191);
        exp_q.push_back('{addr: 22'h201FFF, data: b, cyc: cyc + 32'd1});
        strobe(b);
        check("full_done", 32'(done), 32'd1);
        check("full_last_write", 32'(bus.mem_write), 32'd1);
        check("full_busy_low", 32'(busy), 32'd0);
        check("full_error", 32'(error), 32'd0);
        for (int i = 0; i < 100; i++) strobe(8'(i + 3));
        check("full_pending", 32'(exp_q.size()), 32'd0);
        check("full_done_sticky", 32'(done), 32'd1);
        check("full_flags_hold", mapper_flags, 32'h00000101);
        do_reload();
        check_idle_outputs("reload_after_done");

        // Trainer: 2 PRG, 0 CHR, flags6 bit 2
        send_hdr15(8'd2, 8'd0, 8'h04);
        strobe(8'h00);
        check("trainer_flags", mapper_flags, 32'h00040002);
        for (int i = 0; i < 512; i++) strobe(8'hC3);
        check("trainer_busy", 32'(busy), 32'd1);
        check("trainer_pending", 32'(exp_q.size()), 32'd0);
        send_payload(32767, 22'h000000, 7, 1'b0);
        check("trainer_pre_done", 32'(done), 32'd0);
        b = pat(7 + 32767);
        exp_q.push_back('{addr: 22'h007FFF, data: b, cyc: cyc + 32'd1});
        strobe(b);
        check("trainer_done", 32'(done), 32'd1);
        check("trainer_last_write", 32'(bus.mem_write), 32'd1);
        check("trainer_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) strobe(8'h77);
        check("trainer_end_pending", 32'(exp_q.size()), 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
